alu_seq: RTL and testbench

//  Parametrised, registered successor to the combinational CPU ALU. Keeps the add/sub/and/or/sll/sra
//  op set and adds iterative signed multiply and divide with a start/ready handshake and exception flag.

---
 rtl/alu_seq_pkg.sv | 29 ++
 rtl/alu_multdiv_iter.sv | 97 +++++++++
 rtl/alu_seq.sv | 155 +++++++++++++++
 tb/tb_alu_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package alu_seq_pkg;

    localparam int unsigned OP_DEC_W = 3;

    typedef enum logic [OP_DEC_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLL = 3'd4,
        ALU_SRA = 3'd5,
        ALU_MUL = 3'd6,
        ALU_DIV = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // True for ops that run through the iterative mul/div datapath.
    function automatic logic is_iter_op(input alu_op_e op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/alu_multdiv_iter.sv
// Iterative signed multiply (shift-add) and divide (restoring), one bit per step on magnitudes.
module alu_multdiv_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             step_i,
    output logic             done_c,
    output logic [WIDTH-1:0] result_c,
    output logic             exception_c
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    opnd_q, opnd_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, neg_q;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   trial, diff;
    logic [PW-1:0]    prod_s;
    logic [WIDTH-1:0] quot_s;
    logic             mul_fits;

    assign mag_a = a_i[WIDTH-1] ? (~a_i + WIDTH'(1)) : a_i;
    assign mag_b = b_i[WIDTH-1] ? (~b_i + WIDTH'(1)) : b_i;

    // Next-state for one iteration: load magnitudes, or advance a mul/div step.
    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        trial  = {acc_q[WIDTH-1:0], sreg_q[WIDTH-1]};
        diff   = trial - {1'b0, opnd_q[WIDTH-1:0]};
        if (load_i) begin
            acc_d  = '0;
            cnt_d  = '0;
            sreg_d = div_i ? mag_a : mag_b;
            opnd_d = div_i ? PW'(mag_b) : PW'(mag_a);
        end else if (step_i) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (div_q) begin
                // Partial remainder is always below the divisor, so trial fits WIDTH bits.
                if (!diff[WIDTH]) begin
                    acc_d  = PW'(diff[WIDTH-1:0]);
                    sreg_d = {sreg_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d  = PW'(trial[WIDTH-1:0]);
                    sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d  = acc_q + (sreg_q[0] ? opnd_q : '0);
                opnd_d = opnd_q << 1;
                sreg_d = sreg_q >> 1;
            end
        end
    end

    // Iteration registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            opnd_q <= '0;
            sreg_q <= '0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            if (load_i) begin
                div_q <= div_i;
                neg_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
            end
        end
    end

    // Sign fix-up on the post-step values so the final step's result is available at once.
    always_comb begin
        prod_s   = neg_q ? (~acc_d + PW'(1)) : acc_d;
        quot_s   = neg_q ? (~sreg_d + WIDTH'(1)) : sreg_d;
        mul_fits = (&prod_s[PW-1:WIDTH-1]) || !(|prod_s[PW-1:WIDTH-1]);
        result_c    = div_q ? quot_s : prod_s[WIDTH-1:0];
        exception_c = div_q ? (!neg_q && sreg_d[WIDTH-1]) : !mul_fits;
        done_c      = step_i && (cnt_q == CNT_W'(WIDTH - 1));
    end

endmodule

// File: rtl/alu_seq.sv
// Registered execute-stage ALU: single-cycle add/sub/logic/shift plus iterative mul/div.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SHAMT_W  = $clog2(WIDTH),
    parameter int unsigned OPCODE_W = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ctrl_start,
    input  logic [OPCODE_W-1:0] ctrl_ALUopcode,
    input  logic [SHAMT_W-1:0]  ctrl_shiftamt,
    input  logic [WIDTH-1:0]    data_operandA,
    input  logic [WIDTH-1:0]    data_operandB,
    output logic [WIDTH-1:0]    data_result,
    output logic                data_resultRDY,
    output logic                data_exception,
    output logic                isNotEqual,
    output logic                isLessThan,
    output logic                overflow,
    output logic                busy
);

    state_e           state_q;
    logic [WIDTH-1:0] result_q;
    logic             rdy_q, exc_q, ne_q, lt_q, ovf_q, busy_q;

    alu_op_e          op;
    logic             is_sub, accept, div_zero;
    logic [WIDTH-1:0] b_eff, sum, sc_res;
    logic             sc_ovf, sc_lt, sc_ne, add_ovf;
    logic             it_done, it_exc;
    logic [WIDTH-1:0] it_res;
    logic             unused_opc_hi;

    assign unused_opc_hi = ^ctrl_ALUopcode[OPCODE_W-1:OP_DEC_W];

    assign op       = alu_op_e'(ctrl_ALUopcode[OP_DEC_W-1:0]);
    assign accept   = (state_q == ST_IDLE) && ctrl_start;
    assign div_zero = (data_operandB == '0);
    assign is_sub   = (op == ALU_SUB);
    assign b_eff    = is_sub ? ~data_operandB : data_operandB;
    assign sum      = data_operandA + b_eff + WIDTH'(is_sub);
    assign add_ovf  = (data_operandA[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != data_operandA[WIDTH-1]);

    // Single-cycle result and flags, computed straight from the inputs at the accepting edge.
    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        sc_lt  = 1'b0;
        sc_ne  = 1'b0;
        case (op)
            ALU_ADD: begin
                sc_res = sum;
                sc_ovf = add_ovf;
            end
            ALU_SUB: begin
                sc_res = sum;
                sc_ovf = add_ovf;
                sc_lt  = sum[WIDTH-1] ^ add_ovf;
                sc_ne  = |sum;
            end
            ALU_AND: sc_res = data_operandA & data_operandB;
            ALU_OR:  sc_res = data_operandA | data_operandB;
            ALU_SLL: sc_res = data_operandA << ctrl_shiftamt;
            ALU_SRA: sc_res = WIDTH'($signed(data_operandA) >>> ctrl_shiftamt);
            default: sc_res = '0;
        endcase
    end

    alu_multdiv_iter #(
        .WIDTH (WIDTH),
        .CNT_W (SHAMT_W)
    ) u_iter (
        .clock       (clock),
        .reset       (reset),
        .load_i      (accept && is_iter_op(op) && !((op == ALU_DIV) && div_zero)),
        .div_i       (op == ALU_DIV),
        .a_i         (data_operandA),
        .b_i         (data_operandB),
        .step_i      ((state_q == ST_MUL) || (state_q == ST_DIV)),
        .done_c      (it_done),
        .result_c    (it_res),
        .exception_c (it_exc)
    );

    // Control FSM with registered result, flags, ready pulse and busy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            rdy_q    <= 1'b0;
            exc_q    <= 1'b0;
            ne_q     <= 1'b0;
            lt_q     <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        if (op == ALU_MUL) begin
                            state_q <= ST_MUL;
                        end else if (op == ALU_DIV && !div_zero) begin
                            state_q <= ST_DIV;
                        end else if (op == ALU_DIV) begin
                            state_q  <= ST_DONE;
                            rdy_q    <= 1'b1;
                            result_q <= '0;
                            exc_q    <= 1'b1;
                            ne_q     <= 1'b0;
                            lt_q     <= 1'b0;
                            ovf_q    <= 1'b0;
                        end else begin
                            state_q  <= ST_DONE;
                            rdy_q    <= 1'b1;
                            result_q <= sc_res;
                            exc_q    <= 1'b0;
                            ne_q     <= sc_ne;
                            lt_q     <= sc_lt;
                            ovf_q    <= sc_ovf;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (it_done) begin
                        state_q  <= ST_DONE;
                        rdy_q    <= 1'b1;
                        result_q <= it_res;
                        exc_q    <= it_exc;
                        ne_q     <= 1'b0;
                        lt_q     <= 1'b0;
                        ovf_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_result    = result_q;
    assign data_resultRDY = rdy_q;
    assign data_exception = exc_q;
    assign isNotEqual     = ne_q;
    assign isLessThan     = lt_q;
    assign overflow       = ovf_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_alu_seq;

    typedef struct {
        logic [63:0] res;
        logic        exc, ovf, lt, ne;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start32, start8;
    logic [4:0]  opc;
    logic [4:0]  sh;
    logic [31:0] a, b;

    logic [31:0] res32;
    logic        rdy32, exc32, ne32, lt32, ovf32, busy32;
    logic [7:0]  res8;
    logic        rdy8, exc8, ne8, lt8, ovf8, busy8;

    logic        sel8;
    logic [63:0] c_res;
    logic        c_rdy, c_exc, c_ne, c_lt, c_ovf, c_busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut32 (
        .clock(clk), .reset(rst), .ctrl_start(start32), .ctrl_ALUopcode(opc),
        .ctrl_shiftamt(sh), .data_operandA(a), .data_operandB(b),
        .data_result(res32), .data_resultRDY(rdy32), .data_exception(exc32),
        .isNotEqual(ne32), .isLessThan(lt32), .overflow(ovf32), .busy(busy32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clock(clk), .reset(rst), .ctrl_start(start8), .ctrl_ALUopcode(opc),
        .ctrl_shiftamt(sh[2:0]), .data_operandA(a[7:0]), .data_operandB(b[7:0]),
        .data_result(res8), .data_resultRDY(rdy8), .data_exception(exc8),
        .isNotEqual(ne8), .isLessThan(lt8), .overflow(ovf8), .busy(busy8)
    );

    assign c_res  = sel8 ? 64'(res8) : 64'(res32);
    assign c_rdy  = sel8 ? rdy8  : rdy32;
    assign c_exc  = sel8 ? exc8  : exc32;
    assign c_ne   = sel8 ? ne8   : ne32;
    assign c_lt   = sel8 ? lt8   : lt32;
    assign c_ovf  = sel8 ? ovf8  : ovf32;
    assign c_busy = sel8 ? busy8 : busy32;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour on true signed integers, reduced to w bits at the end.
    function automatic exp_t model(input int w, input logic [2:0] op, input logic [31:0] av,
                                   input logic [31:0] bv, input int shv);
        exp_t  e;
        longint mask, sa, sb, r, mn, mx;
        mask = (longint'(1) <<< w) - 1;
        sa = longint'(av) & mask;
        sb = longint'(bv) & mask;
        if (sa >= (longint'(1) <<< (w - 1))) sa = sa - (longint'(1) <<< w);
        if (sb >= (longint'(1) <<< (w - 1))) sb = sb - (longint'(1) <<< w);
        mn = -(longint'(1) <<< (w - 1));
        mx = -mn - 1;
        e.exc = 1'b0; e.ovf = 1'b0; e.lt = 1'b0; e.ne = 1'b0; e.lat = 1;
        r = 0;
        case (op)
            3'd0: begin r = sa + sb; e.ovf = (r < mn) || (r > mx); end
            3'd1: begin r = sa - sb; e.ovf = (r < mn) || (r > mx); e.lt = sa < sb; e.ne = sa != sb; end
            3'd2: r = sa & sb;
            3'd3: r = sa | sb;
            3'd4: r = sa <<< shv;
            3'd5: r = sa >>> shv;
            3'd6: begin r = sa * sb; e.exc = (r < mn) || (r > mx); e.lat = w + 1; end
            default: begin
                if (sb == 0) begin
                    r = 0; e.exc = 1'b1;
                end else begin
                    r = sa / sb; e.exc = r > mx; e.lat = w + 1;
                end
            end
        endcase
        e.res = 64'(r & mask);
        return e;
    endfunction

    // One operation: pulse start, wait for RDY (bounded), check latency, result, flags, busy.
    task automatic run(input bit w8, input logic [2:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic [4:0] shv, input int poke);
        exp_t e;
        int   lat;
        int   w;
        w = w8 ? 8 : 32;
        e = model(w, op, av, bv, w8 ? int'(shv[2:0]) : int'(shv));
        sel8 = w8;
        opc = {2'($urandom_range(3, 0)), op};
        a = av; b = bv; sh = shv;
        start8 = w8; start32 = !w8;
        @(posedge clk); #1;
        start8 = 1'b0; start32 = 1'b0;
        a = $urandom; b = $urandom; sh = 5'($urandom);
        lat = 1;
        while (!c_rdy && lat < 100) begin
            if (lat == poke) begin
                opc = 5'd0;
                start8 = w8; start32 = !w8;
            end else begin
                start8 = 1'b0; start32 = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start8 = 1'b0; start32 = 1'b0;
        check($sformatf("lat w%0d op%0d", w, op), 64'(lat), 64'(e.lat));
        check($sformatf("res w%0d op%0d a=%h b=%h", w, op, av, bv), c_res, e.res);
        check($sformatf("exc w%0d op%0d", w, op), 64'(c_exc), 64'(e.exc));
        check($sformatf("ovf w%0d op%0d", w, op), 64'(c_ovf), 64'(e.ovf));
        check($sformatf("lt w%0d op%0d", w, op), 64'(c_lt), 64'(e.lt));
        check($sformatf("ne w%0d op%0d", w, op), 64'(c_ne), 64'(e.ne));
        check($sformatf("busy@rdy w%0d op%0d", w, op), 64'(c_busy), 64'(1));
        @(posedge clk); #1;
        check($sformatf("rdy_after w%0d op%0d", w, op), 64'(c_rdy), 64'(0));
        check($sformatf("busy_after w%0d op%0d", w, op), 64'(c_busy), 64'(0));
        check($sformatf("res_hold w%0d op%0d", w, op), c_res, e.res);
    endtask

    function automatic logic [31:0] rand_opnd();
        logic [31:0] corners [8];
        corners = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h7F, 32'h80, 32'hFF};
        case ($urandom_range(2, 0))
            0:       return 32'($urandom_range(40, 0)) - 32'd20;
            1:       return $urandom;
            default: return corners[$urandom_range(7, 0)];
        endcase
    endfunction

    initial begin
        int pulses;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        rst = 1'b1; start32 = 1'b0; start8 = 1'b0; sel8 = 1'b0;
        opc = '0; sh = '0; a = '0; b = '0;
        @(posedge clk); #1;
        check("reset res32", 64'(res32), 64'(0));
        check("reset rdy32", 64'(rdy32), 64'(0));
        check("reset busy32", 64'(busy32), 64'(0));
        check("reset flags32", 64'({exc32, ne32, lt32, ovf32}), 64'(0));
        check("reset res8", 64'(res8), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases, 32-bit
        run(0, 3'd1, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0, -1);
        run(0, 3'd6, 32'hFFFFFFF9, 32'd6, 5'd0, -1);
        run(0, 3'd6, 32'h00010000, 32'h00010000, 5'd0, -1);
        run(0, 3'd7, 32'hFFFFFF9C, 32'd7, 5'd0, -1);
        run(0, 3'd7, 32'd5, 32'd0, 5'd0, -1);
        run(0, 3'd7, 32'd1000, 32'hFFFFFFFD, 5'd0, 5);
        run(0, 3'd5, 32'h80000000, 32'd0, 5'd31, -1);
        run(0, 3'd4, 32'd1, 32'd0, 5'd31, -1);
        run(0, 3'd7, 32'h80000000, 32'hFFFFFFFF, 5'd0, -1);
        run(0, 3'd0, 32'h7FFFFFFF, 32'd1, 5'd0, -1);

        // Same mul/div corners at WIDTH=8
        run(1, 3'd6, 32'hF9, 32'd6, 5'd0, -1);
        run(1, 3'd6, 32'h10, 32'h10, 5'd0, -1);
        run(1, 3'd7, 32'h9C, 32'd7, 5'd0, -1);
        run(1, 3'd7, 32'd5, 32'd0, 5'd0, -1);
        run(1, 3'd7, 32'h80, 32'hFF, 5'd0, 3);
        run(1, 3'd5, 32'h80, 32'd0, 5'd7, -1);

        // Reset in the middle of a 32-bit multiply
        sel8 = 1'b0;
        opc = 5'd6; a = 32'd12345; b = 32'd678;
        start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst busy", 64'(busy32), 64'(0));
        check("midrst rdy", 64'(rdy32), 64'(0));
        check("midrst res", 64'(res32), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (rdy32) pulses++;
        end
        check("midrst no rdy", 64'(pulses), 64'(0));
        run(0, 3'd6, 32'hFFFFFFF9, 32'd6, 5'd0, -1);

        // Random mix at both widths
        for (int i = 0; i < 120; i++) begin
            rop = 3'($urandom_range(7, 0));
            ra = rand_opnd();
            rb = rand_opnd();
            if (rop == 3'd7 && $urandom_range(5, 0) == 0) rb = 32'd0;
            run(1'($urandom_range(1, 0)), rop, ra, rb, 5'($urandom), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
